// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared op codes, address width default and issuer state enum
package cache_pkg;

  localparam int DEF_ADDR_W = 48;
  localparam int DEF_OP_W   = 8;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_L1,
    ST_WAIT_L2,
    ST_GAP
  } issuer_state_t;

endpackage

// File: rtl/trace_issuer_if.sv
// rtl/trace_issuer_if.sv - trace input stream and engine request/completion bundle
interface trace_issuer_if #(
  parameter int ADDR_W = 48,
  parameter int OP_W   = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [OP_W-1:0]   out_op;
  logic              out_lvl;
  logic              eng_done;

  // Trace source and engine side
  modport master (
    output in_valid, in_addr, in_op, eng_done,
    input  in_ready, out_valid, out_addr, out_op, out_lvl
  );

  // Issuer side
  modport slave (
    input  in_valid, in_addr, in_op, eng_done,
    output in_ready, out_valid, out_addr, out_op, out_lvl
  );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with extra-MSB pointer wrap
module trace_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers; reset empties the FIFO immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/trace_issuer.sv
// rtl/trace_issuer.sv - buffers trace entries and presents them to the cache engine at L1 then L2
module trace_issuer
  import cache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int OP_W       = DEF_OP_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          reset,
  trace_issuer_if.slave bus,
  input  logic          two_level,
  output logic          busy,
  output logic [15:0]   issued_cnt,
  output logic [15:0]   write_cnt,
  output logic [7:0]    bad_op_cnt,
  output logic          timeout_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  issuer_state_t       r_state;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [OP_W-1:0]     r_out_op;
  logic                r_out_lvl;
  logic                r_out_valid;
  logic                r_lvl2_en;
  logic [TW-1:0]       r_timer;
  logic [15:0]         r_issued_cnt;
  logic [15:0]         r_write_cnt;
  logic [7:0]          r_bad_op_cnt;
  logic                r_timeout_err;

  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [OP_W+ADDR_W-1:0] w_head;
  logic                w_accept;
  logic                w_legal;
  logic                w_push;
  logic                w_pop;
  logic                w_expired;
  logic                w_done;

  // in_ready is held low while reset is asserted and follows !full otherwise
  assign bus.in_ready = reset && !w_full;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_legal      = (bus.in_op == OP_READ) || (bus.in_op == OP_WRITE);
  assign w_push       = w_accept && w_legal;
  assign w_pop        = (r_state == ST_IDLE) && !w_empty;
  // Expiry only counts when the engine did not answer in the same cycle
  assign w_expired    = (r_timer == TW'(TIMEOUT - 1)) && !bus.eng_done;
  assign w_done       = bus.eng_done || w_expired;

  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_op    = r_out_op;
  assign bus.out_lvl   = r_out_lvl;
  assign busy          = (r_state != ST_IDLE) || (w_count != '0);
  assign issued_cnt    = r_issued_cnt;
  assign write_cnt     = r_write_cnt;
  assign bad_op_cnt    = r_bad_op_cnt;
  assign timeout_err   = r_timeout_err;

  trace_fifo #(
    .WIDTH (OP_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({bus.in_op, bus.in_addr}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Illegal ops are consumed from the stream and only counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bad_op_cnt <= '0;
    end else if (w_accept && !w_legal && (r_bad_op_cnt != '1)) begin
      r_bad_op_cnt <= r_bad_op_cnt + 1'b1;
    end
  end

  // Issue FSM with registered request outputs, presentation timer and issue statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_out_addr    <= '0;
      r_out_op      <= '0;
      r_out_lvl     <= 1'b1;
      r_out_valid   <= 1'b0;
      r_lvl2_en     <= 1'b0;
      r_timer       <= '0;
      r_issued_cnt  <= '0;
      r_write_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_out_addr  <= w_head[ADDR_W-1:0];
            r_out_op    <= w_head[OP_W+ADDR_W-1:ADDR_W];
            r_out_lvl   <= 1'b1;
            r_out_valid <= 1'b1;
            r_lvl2_en   <= two_level;
            r_timer     <= '0;
            r_state     <= ST_WAIT_L1;
          end
        end
        ST_WAIT_L1, ST_WAIT_L2: begin
          if (w_done) begin
            if (w_expired) r_timeout_err <= 1'b1;
            if ((r_state == ST_WAIT_L1) && r_lvl2_en) begin
              r_out_lvl <= 1'b0;
              r_timer   <= '0;
              r_state   <= ST_WAIT_L2;
            end else begin
              r_out_valid <= 1'b0;
              if (r_issued_cnt != '1) r_issued_cnt <= r_issued_cnt + 1'b1;
              if ((r_out_op == OP_WRITE) && (r_write_cnt != '1)) r_write_cnt <= r_write_cnt + 1'b1;
              r_state <= ST_GAP;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trace_issuer.sv
// tb/tb_trace_issuer.sv - scoreboard bench for trace_issuer
module tb_trace_issuer;
  logic        clk = 1'b0;
  logic        reset;
  logic        two_level;
  logic        busy;
  logic [15:0] issued_cnt;
  logic [15:0] write_cnt;
  logic [7:0]  bad_op_cnt;
  logic        timeout_err;

  trace_issuer_if #(.ADDR_W(48), .OP_W(8)) bus ();

  trace_issuer #(
    .ADDR_W     (48),
    .OP_W       (8),
    .FIFO_DEPTH (8),
    .TIMEOUT    (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .two_level   (two_level),
    .busy        (busy),
    .issued_cnt  (issued_cnt),
    .write_cnt   (write_cnt),
    .bad_op_cnt  (bad_op_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] addr;
    logic [7:0]  op;
    logic        lvl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic        m_prev_valid = 1'b0;
  logic        m_prev_lvl   = 1'b1;
  logic [47:0] m_prev_addr  = '0;
  logic [7:0]  m_prev_op    = '0;

  // Monitor: every new presentation (valid rise or level change) is scored against the queue
  always @(negedge clk) begin
    if (bus.out_valid && (!m_prev_valid || (bus.out_lvl != m_prev_lvl))) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL present_unexpected got addr=%h op=%h lvl=%0d required no request",
                 bus.out_addr, bus.out_op, bus.out_lvl);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.out_addr !== e.addr || bus.out_op !== e.op || bus.out_lvl !== e.lvl) begin
          n_bad++;
          $display("FAIL present got addr=%h op=%h lvl=%0d required addr=%h op=%h lvl=%0d",
                   bus.out_addr, bus.out_op, bus.out_lvl, e.addr, e.op, e.lvl);
        end
      end
    end else if (bus.out_valid && m_prev_valid &&
                 (bus.out_addr !== m_prev_addr || bus.out_op !== m_prev_op)) begin
      n_vec++;
      n_bad++;
      $display("FAIL hold got addr=%h op=%h required addr=%h op=%h",
               bus.out_addr, bus.out_op, m_prev_addr, m_prev_op);
    end
    m_prev_valid = bus.out_valid;
    m_prev_lvl   = bus.out_lvl;
    m_prev_addr  = bus.out_addr;
    m_prev_op    = bus.out_op;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // Offer one entry and hold it until the handshake edge; legal ops are queued as expectations
  task automatic push(input logic [47:0] addr, input logic [7:0] op);
    int tries = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_op    = op;
    while (!bus.in_ready && tries < 200) begin
      tick();
      tries++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout got in_ready=0 required 1");
    end else if (op == 8'h52 || op == 8'h57) begin
      exp_q.push_back('{addr: addr, op: op, lvl: 1'b1});
      if (two_level) exp_q.push_back('{addr: addr, op: op, lvl: 1'b0});
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic done_pulse();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int tries = 0;
    while (!bus.out_valid && tries < 20) begin
      tick();
      tries++;
    end
    check(name, 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    int cyc;
    reset        = 1'b0;
    two_level    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_op    = '0;
    bus.eng_done = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_lvl", 64'(bus.out_lvl), 64'd1);
    check("rst_out_addr", 64'(bus.out_addr), 64'd0);
    check("rst_counters", {issued_cnt, write_cnt, bad_op_cnt, 7'd0, timeout_err}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Single read, L1 only: one-cycle latency, completion on the fourth edge
    push(48'h1000, 8'h52);
    check("t1_not_yet", 64'(bus.out_valid), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    tick();
    tick();
    done_pulse();
    check("t1_cleared", 64'(bus.out_valid), 64'd0);
    check("t1_issued", 64'(issued_cnt), 64'd1);
    check("t1_writes", 64'(write_cnt), 64'd0);
    // eng_done during GAP must be ignored
    done_pulse();
    tick();
    check("t1_gap_done_ignored", 64'(issued_cnt), 64'd1);

    // Two-level write
    two_level = 1'b1;
    push(48'h2040, 8'h57);
    tick();
    check("t2_lvl1", 64'(bus.out_lvl), 64'd1);
    done_pulse();
    check("t2_still_valid", 64'(bus.out_valid), 64'd1);
    check("t2_lvl2", 64'(bus.out_lvl), 64'd0);
    check("t2_addr_held", 64'(bus.out_addr), 64'h2040);
    done_pulse();
    check("t2_cleared", 64'(bus.out_valid), 64'd0);
    check("t2_issued", 64'(issued_cnt), 64'd2);
    check("t2_writes", 64'(write_cnt), 64'd1);
    tick();
    tick();
    two_level = 1'b0;

    // Illegal op: accepted, counted, never presented
    check("t3_ready", 64'(bus.in_ready), 64'd1);
    push(48'h3000, 8'h41);
    check("t3_bad_op", 64'(bad_op_cnt), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("t3_no_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: 8 stored plus 1 in flight, then drain in order
    for (int i = 0; i < 9; i++) push(48'h4000 + 48'(i * 64), (i % 2 == 1) ? 8'h57 : 8'h52);
    check("t4_full_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("t4_full_ready_hold", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 9; i++) begin
      wait_valid("t4_drain_valid");
      done_pulse();
    end
    tick();
    tick();
    check("t4_issued", 64'(issued_cnt), 64'd11);
    check("t4_writes", 64'(write_cnt), 64'd5);
    check("t4_drained", 64'(busy), 64'd0);

    // eng_done coinciding with the expiry cycle wins without error
    push(48'h5000, 8'h52);
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("t5_valid_at_63", 64'(bus.out_valid), 64'd1);
    done_pulse();
    check("t5_done_wins", 64'(timeout_err), 64'd0);
    check("t5_cleared", 64'(bus.out_valid), 64'd0);
    check("t5_issued", 64'(issued_cnt), 64'd12);
    tick();
    tick();

    // Timeout: no eng_done, valid lasts exactly 64 cycles
    push(48'h5040, 8'h52);
    tick();
    cyc = 0;
    while (bus.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t6_valid_cycles", 64'(cyc), 64'd64);
    check("t6_timeout_err", 64'(timeout_err), 64'd1);
    check("t6_issued", 64'(issued_cnt), 64'd13);
    tick();
    tick();
    tick();
    check("t6_err_sticky", 64'(timeout_err), 64'd1);

    // Async reset in WAIT_L2 with a second entry still buffered
    two_level = 1'b1;
    push(48'h6000, 8'h57);
    push(48'h6040, 8'h52);
    check("t7_l1", 64'(bus.out_lvl), 64'd1);
    done_pulse();
    check("t7_in_l2", 64'(bus.out_lvl), 64'd0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t7_valid_async", 64'(bus.out_valid), 64'd0);
    check("t7_fifo_empty", 64'(busy), 64'd0);
    check("t7_ready_low", 64'(bus.in_ready), 64'd0);
    check("t7_lvl", 64'(bus.out_lvl), 64'd1);
    check("t7_counters", {issued_cnt, write_cnt, bad_op_cnt, 7'd0, timeout_err}, 64'd0);
    tick();
    reset = 1'b1;
    two_level = 1'b0;
    tick();
    check("t7_ready_after", 64'(bus.in_ready), 64'd1);
    tick();
    tick();
    check("t7_idle_after", 64'(bus.out_valid), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
